// File: rtl/ppu_pkg.sv
// ----------------------------------------------------------------------------
// ppu_pkg
// Shared constants, types and helpers for the posit8 (es=0) processing unit.
//   - posit format constants and clamp limits on the combined scale k
//   - special encodings (NaR, zero) and saturation bodies (maxpos, minpos)
//   - p8_fields_t : raw multiplier product fields
//   - s1_t        : stage-1 register contents of p8_round_encode_pipe
// ----------------------------------------------------------------------------
package ppu_pkg;

    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 0;

    // Scale range that still has a regime fitting into the 7-bit body.
    localparam logic signed [7:0] K_MAX = 8'sd6;
    localparam logic signed [7:0] K_MIN = -8'sd6;

    localparam logic [7:0] P8_NAR      = 8'h80;
    localparam logic [7:0] P8_ZERO     = 8'h00;
    localparam logic [6:0] BODY_MAXPOS = 7'h7F;
    localparam logic [6:0] BODY_MINPOS = 7'h01;

    localparam int P8_FRAC_W = 8;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           k;
        logic [P8_FRAC_W-1:0] frac;
        logic                 guard;
        logic                 sticky;
        logic                 zero;
        logic                 nar;
    } p8_fields_t;

    typedef struct packed {
        logic       sign;
        logic       zero;
        logic       nar;
        logic [6:0] body_raw;
        logic       rb;
        logic       st;
        logic       sat_hi;
        logic       sat_lo;
    } s1_t;

    // Attach the sign to a positive body: posits negate by two's complement
    // of the whole word.
    function automatic logic [7:0] p8_apply_sign(input logic sign, input logic [6:0] body);
        logic [7:0] w_p;
        w_p = {1'b0, body};
        return sign ? (8'd0 - w_p) : w_p;
    endfunction

endpackage

// File: rtl/p8_regime_pack.sv
// ----------------------------------------------------------------------------
// p8_regime_pack
// Combinational regime packer for posit8 (es=0). Builds the bit string
// {regime, frac, guard} and cuts it into the 7-bit body, round bit and
// sticky bit. Flags scales outside [K_MIN, K_MAX] for saturation; the body
// outputs are don't-care in that case.
// Ports:
//   i_k        signed scale (value = 2^k * 1.frac)
//   i_frac     fraction, MSB-aligned, hidden bit excluded
//   i_guard    first bit below i_frac
//   i_sticky   OR of all bits below guard
//   o_body_raw top 7 bits of the string (unrounded body)
//   o_rb       round bit (first bit below the body)
//   o_st       sticky (OR of everything below the round bit)
//   o_sat_hi   k > K_MAX
//   o_sat_lo   k < K_MIN
// ----------------------------------------------------------------------------
module p8_regime_pack
    import ppu_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic [7:0]        i_k,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_guard,
    input  logic              i_sticky,
    output logic [6:0]        o_body_raw,
    output logic              o_rb,
    output logic              o_st,
    output logic              o_sat_hi,
    output logic              o_sat_lo
);

    // Longest regime is 8 bits (k=6), followed by frac and guard.
    localparam int STR_W = 8 + FRAC_W + 1;

    logic [7:0]       w_k_cl;
    logic             w_neg;
    logic [7:0]       w_ones;
    logic [7:0]       w_zeros;
    logic [7:0]       w_len;
    logic [STR_W-1:0] w_regime;
    logic [STR_W-1:0] w_tail;
    logic [STR_W-1:0] w_str;

    assign o_sat_hi = $signed(i_k) > K_MAX;
    assign o_sat_lo = $signed(i_k) < K_MIN;

    // Clamp out-of-range scales to 0 so the shifters never see huge amounts.
    assign w_k_cl  = (o_sat_hi || o_sat_lo) ? 8'd0 : i_k;
    assign w_neg   = w_k_cl[7];
    assign w_ones  = w_k_cl + 8'd1;
    assign w_zeros = 8'd0 - w_k_cl;
    assign w_len   = w_neg ? (w_zeros + 8'd1) : (w_ones + 8'd1);

    // k>=0: run of (k+1) ones, terminating 0 comes from the empty mask bit.
    // k<0 : (-k) zeros, then a single terminating 1.
    assign w_regime = w_neg ? ({1'b1, {(STR_W-1){1'b0}}} >> w_zeros)
                            : ~({STR_W{1'b1}} >> w_ones);

    assign w_tail = {i_frac, i_guard, 8'd0};
    assign w_str  = w_regime | (w_tail >> w_len);

    assign o_body_raw = w_str[STR_W-1 -: 7];
    assign o_rb       = w_str[STR_W-8];
    assign o_st       = (|w_str[STR_W-9:0]) | i_sticky;

endmodule

// File: rtl/p8_round_encode_pipe.sv
// ----------------------------------------------------------------------------
// p8_round_encode_pipe
// Two-stage valid/ready pipeline turning raw posit8 (es=0) product fields into
// a correctly rounded posit8 (round-to-nearest-even, saturating to
// maxpos/minpos, NaR/zero override, two's-complement negation).
// Stage 1 packs the regime; stage 2 rounds, saturates, signs and overrides.
// Optional macro PPU_ENC_STATUS_EN adds saturation status outputs.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    input handshake (in_ready depends on out_ready)
//   in_sign, in_k, in_frac, in_guard, in_sticky, in_zero, in_nar
//                          raw product fields (nar overrides zero)
//   out_valid / out_ready  output handshake
//   out_p8                 encoded posit8, stable while stalled
//   out_sat  (macro)       out_p8 came from saturation
//   sat_cnt  (macro)       count of transferred saturated results, sticky max
// ----------------------------------------------------------------------------
module p8_round_encode_pipe
    import ppu_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [7:0]        in_k,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic              in_guard,
    input  logic              in_sticky,
    input  logic              in_zero,
    input  logic              in_nar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_p8
`ifdef PPU_ENC_STATUS_EN
    ,
    output logic              out_sat,
    output logic [15:0]       sat_cnt
`endif
);

    logic       r_s1_valid;
    s1_t        r_s1;
    logic       r_s2_valid;
    logic [7:0] r_out_p8;

    logic       w_s1_adv;
    logic       w_in_ready;
    logic       w_accept;
    s1_t        w_s1_next;
    logic       w_round_up;
    logic [6:0] w_body;
    logic [7:0] w_p8;

    // Handshake: stage 1 can move on when stage 2 is empty or draining.
    assign w_s1_adv   = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept   = in_valid && w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign out_p8    = r_out_p8;

    // ---------------- stage 1: regime packing ----------------
    p8_regime_pack #(.FRAC_W(FRAC_W)) u_regime_pack (
        .i_k        (in_k),
        .i_frac     (in_frac),
        .i_guard    (in_guard),
        .i_sticky   (in_sticky),
        .o_body_raw (w_s1_next.body_raw),
        .o_rb       (w_s1_next.rb),
        .o_st       (w_s1_next.st),
        .o_sat_hi   (w_s1_next.sat_hi),
        .o_sat_lo   (w_s1_next.sat_lo)
    );

    assign w_s1_next.sign = in_sign;
    assign w_s1_next.zero = in_zero;
    assign w_s1_next.nar  = in_nar;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed when
    // the matching valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1 <= w_s1_next;
        end
    end

    // ---------------- stage 2: round, saturate, sign, override ----------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_round_up = 1'b0;
        w_body     = r_s1.body_raw;
        w_p8       = P8_ZERO;

        // Nearest-even; maxpos never rounds up into NaR.
        w_round_up = r_s1.rb && (r_s1.st || r_s1.body_raw[0])
                     && (r_s1.body_raw != BODY_MAXPOS);

        if (r_s1.sat_hi) begin
            w_body = BODY_MAXPOS;
        end else if (r_s1.sat_lo) begin
            w_body = BODY_MINPOS;
        end else begin
            w_body = r_s1.body_raw + {6'd0, w_round_up};
        end

        if (r_s1.nar) begin
            w_p8 = P8_NAR;
        end else if (r_s1.zero) begin
            w_p8 = P8_ZERO;
        end else begin
            w_p8 = p8_apply_sign(r_s1.sign, w_body);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_p8   <= P8_ZERO;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            // Only load real data so the output word stays meaningful.
            if (r_s1_valid) begin
                r_out_p8 <= w_p8;
            end
        end
    end

`ifdef PPU_ENC_STATUS_EN
    logic        r_out_sat;
    logic [15:0] r_sat_cnt;
    logic        w_sat;

    assign w_sat   = (r_s1.sat_hi || r_s1.sat_lo) && !r_s1.nar && !r_s1.zero;
    assign out_sat = r_out_sat;
    assign sat_cnt = r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_sat <= 1'b0;
            r_sat_cnt <= 16'd0;
        end else begin
            if (w_s1_adv && r_s1_valid) begin
                r_out_sat <= w_sat;
            end
            if (r_s2_valid && out_ready && r_out_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/p8_round_encode_pipe.md
Name: p8_round_encode_pipe

Overview:
- Two-stage valid/ready pipeline that consumes the raw product fields of the posit8 (es=0) multiplier and produces a correctly rounded posit8.
- Raw product fields: sign, combined scale k, fraction, guard, sticky.
- Performs regime packing, round-to-nearest-even, saturation to maxpos/minpos, special-value override and two's-complement negation.
- Sits directly downstream of the posit8 multiplier datapath and drives the PPU result bus.

Parameters:
- FRAC_W, 8, width of the incoming fraction field (hidden bit excluded, MSB-aligned).

Ports:
- clk        in   1       rising-edge clock
- rst_n      in   1       reset, synchronous, active-low
- in_valid   in   1       input fields valid
- in_ready   out  1       block can accept input this cycle
- in_sign    in   1       result sign
- in_k       in   8       signed scale; value = 2^k * 1.frac
- in_frac    in   FRAC_W  fraction bits, MSB first
- in_guard   in   1       first bit below in_frac
- in_sticky  in   1       OR of all bits below guard
- in_zero    in   1       result is exactly zero
- in_nar     in   1       result is NaR; overrides in_zero
- out_valid  out  1       out_p8 valid
- out_ready  in   1       consumer accepts out_p8
- out_p8     out  8       encoded posit8

Behaviour:
- Reset, synchronous on rst_n=0: s1_valid=0, s2_valid=0, out_valid=0, out_p8=8'h00. Reset mid-operation discards all in-flight data.
- Handshake:
  - s1_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv. This is a combinational path from out_ready.
  - Transfer occurs when valid && ready.
  - out_p8 holds stable while out_valid=1 and out_ready=0.
  - No loss, no duplication, order preserved.
- Latency: 2 cycles from input acceptance to out_valid. Full throughput of 1/cycle when out_ready=1.
- Stage 1 (register on acceptance):
  - Clamp flags: sat_hi = k>6; sat_lo = k<-6.
  - Regime for k>=0: (k+1) ones then 0. For k<0: (-k) zeros then 1.
  - Form string {regime, frac, guard}.
  - body_raw = top 7 bits.
  - rb = next bit.
  - st = OR(remaining bits, in_sticky).
  - Register sign, zero, nar, body_raw, rb, st, sat_hi, sat_lo.
- Stage 2 (register when s1_adv):
  - Round up iff rb && (st || body_raw[0]).
  - If body_raw=7'h7F, rounding is suppressed.
  - Result body is never 0: the k>=-6 regime always contains a 1.
  - Saturation: sat_hi gives body=7'h7F; sat_lo gives body=7'h01. Posits never round to zero or NaR.
  - p = {1'b0, body}; if sign=1, p = -p (8-bit two's complement).
  - Overrides, priority nar > zero: nar gives 8'h80; zero gives 8'h00, regardless of sign.
- Both stages full and out_ready=0: in_ready=0, pipeline holds.
- Simultaneous output drain and input accept in the same cycle is legal.

Optional Feature:
- Macro: PPU_ENC_STATUS_EN.
- Defined:
  - Adds out_sat (out, 1): 1 when out_p8 came from sat_hi/sat_lo, cycle-aligned with out_p8.
  - Adds sat_cnt (out, 16): counts transferred saturated results, saturates at 16'hFFFF, reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ppu_pkg holds:
  - POSIT_N=8, POSIT_ES=0, K_MAX=6, K_MIN=-6.
  - P8_NAR=8'h80, P8_ZERO=8'h00, BODY_MAXPOS=7'h7F, BODY_MINPOS=7'h01.
  - typedef struct packed p8_fields_t {sign, k, frac, guard, sticky, zero, nar}.
- One combinational sub-module, p8_regime_pack: (k, frac, guard, sticky) -> (body_raw, rb, st, sat_hi, sat_lo). It is instantiated in stage 1.

Test Plan:
- sign=0, k=0, frac=0x00 -> out_p8=0x40 after 2 cycles. Same with sign=1 -> 0xC0.
- k=1, frac=0x80, guard=0, sticky=0 (3.0) -> 0x68.
- k=0, frac=0b00001100 -> 0x42 (tie, odd LSB rounds up). frac=0b00000100 -> 0x40 (tie, even holds). frac=0b00000100 with sticky=1 -> 0x41.
- k=9 -> 0x7F. sign=1, k=-8 -> 0xFF. nar=1 with zero=1 -> 0x80. zero=1, sign=1 -> 0x00.
- Backpressure: stream 4 inputs with out_ready=0 for 3 cycles.
  - Check in_ready falls after 2 accepts.
  - Check out_p8 is stable while stalled.
  - Release: all 4 results emerge in order, no duplicates.
- Assert rst_n=0 with both stages full -> next cycle out_valid=0, in_ready=1. Post-reset input yields a correct result 2 cycles later.
